// File: rtl/if_fetch_frontend_pkg.sv
// Shared fetch front-end types.
// IF/ID bundle, FSM encoding, NOP word.
package if_fetch_frontend_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fe_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            valid;
  } ifid_t;

endpackage

// File: rtl/if_fetch_frontend_ifid.sv
// IF/ID pipeline register.
// Bubble beats load; neither means hold.
module ifid_reg
  import if_fetch_frontend_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_WORD = 32'h0000_0013
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  bubble,
  input  ifid_t d,
  output ifid_t q
);

  // Register update: bubble, load or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '{pc: '0, instr: NOP_WORD, valid: 1'b0};
    end else if (bubble) begin
      q <= '{pc: d.pc, instr: NOP_WORD, valid: 1'b0};
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_fetch_frontend.sv
// Fetch front end: PC, imem handshake,
// stall buffer and IF/ID register.
module if_fetch_frontend
  import if_fetch_frontend_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR =
    if_fetch_frontend_pkg::NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        PCWrite_i,
  input  logic        Stall_i,
  input  logic        Flush_i,
  input  logic [31:0] BranchTarget_i,
  output logic        IMemReq_o,
  output logic [31:0] IMemAddr_o,
  input  logic        IMemReady_i,
  input  logic [31:0] IMemInstr_i,
  output logic [31:0] IFID_PC_o,
  output logic [31:0] IFID_Instr_o,
  output logic        IFID_Valid_o
);

  fe_state_t   state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] hold_buf, hold_n;
  logic [31:0] redir, redir_n;
  logic [31:0] target, pc_inc;
  logic        flush, load, bubble;
  ifid_t       ifid_d, ifid_q;

  // A stalled ID slot cannot hold a resolved branch.
  assign flush  = Flush_i & ~Stall_i;
  assign target = BranchTarget_i & ~32'd3;
  assign pc_inc = pc + 32'd4;

  assign IMemReq_o  = (state == FETCH) ||
                      (state == DRAIN);
  assign IMemAddr_o = pc;

  assign ifid_d = '{
    pc:    pc,
    instr: (state == HOLD) ? hold_buf
                           : IMemInstr_i,
    valid: 1'b1
  };

  // Next-state, PC and IF/ID control decode.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    hold_n  = hold_buf;
    redir_n = redir;
    load    = 1'b0;
    bubble  = 1'b0;
    unique case (state)
      IDLE: state_n = FETCH;
      FETCH: begin
        if (IMemReady_i) begin
          if (flush) begin
            pc_n   = target;
            bubble = 1'b1;
          end else if (Stall_i) begin
            hold_n  = IMemInstr_i;
            state_n = HOLD;
          end else begin
            load = 1'b1;
            if (PCWrite_i) pc_n = pc_inc;
          end
        end else if (flush) begin
          redir_n = target;
          bubble  = 1'b1;
          state_n = DRAIN;
        end else if (!Stall_i) begin
          bubble = 1'b1;
        end
      end
      DRAIN: begin
        // Owed response is swallowed; latest target wins.
        if (flush) redir_n = target;
        bubble = ~Stall_i;
        if (IMemReady_i) begin
          pc_n    = redir_n;
          state_n = FETCH;
        end
      end
      HOLD: begin
        if (!Stall_i) begin
          state_n = FETCH;
          if (Flush_i) begin
            pc_n   = target;
            bubble = 1'b1;
          end else begin
            load = 1'b1;
            if (PCWrite_i) pc_n = pc_inc;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM, PC, stall buffer and redirect state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      hold_buf <= NOP_INSTR;
      redir    <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      hold_buf <= hold_n;
      redir    <= redir_n;
    end
  end

  ifid_reg #(
    .NOP_WORD (NOP_INSTR)
  ) u_ifid (
    .clk    (clk_i),
    .rst_n  (rst_n_i),
    .load   (load),
    .bubble (bubble),
    .d      (ifid_d),
    .q      (ifid_q)
  );

  assign IFID_PC_o    = ifid_q.pc;
  assign IFID_Instr_o = ifid_q.instr;
  assign IFID_Valid_o = ifid_q.valid;

endmodule

// File: tb/tb_if_fetch_frontend.sv
// Directed bench for if_fetch_frontend.
// Latency-programmable imem model.
module tb_if_fetch_frontend;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    bit          stall;
    bit          flush;
    bit          pcw;
    logic [31:0] tgt;
    bit          e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_addr;
    bit          e_req;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pcw, stall, flush;
  logic [31:0] tgt;
  logic        req, ready;
  logic [31:0] addr, instr;
  logic [31:0] ifid_pc, ifid_instr;
  logic        ifid_valid;

  int lat = 0;
  int cnt;
  int checks = 0;
  int failures = 0;

  vec_t t1[5];
  vec_t t2[7];

  always #5 clk = ~clk;

  if_fetch_frontend dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .PCWrite_i      (pcw),
    .Stall_i        (stall),
    .Flush_i        (flush),
    .BranchTarget_i (tgt),
    .IMemReq_o      (req),
    .IMemAddr_o     (addr),
    .IMemReady_i    (ready),
    .IMemInstr_i    (instr),
    .IFID_PC_o      (ifid_pc),
    .IFID_Instr_o   (ifid_instr),
    .IFID_Valid_o   (ifid_valid)
  );

  function automatic logic [31:0] mem_word(
    input logic [31:0] a);
    return a ^ 32'h5A00_0003;
  endfunction

  assign ready = req && (cnt == lat);
  assign instr = mem_word(addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 0;
    else if (!req || ready) cnt <= 0;
    else cnt <= cnt + 1;
  end

  function automatic vec_t mk(
    input bit st, input bit fl, input bit pw,
    input logic [31:0] tg, input bit ev,
    input logic [31:0] ep, input logic [31:0] ea,
    input bit er);
    vec_t v;
    v.stall = st; v.flush = fl; v.pcw = pw;
    v.tgt = tg; v.e_valid = ev; v.e_pc = ep;
    v.e_addr = ea; v.e_req = er;
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit st, input bit fl,
                       input bit pw,
                       input logic [31:0] tg);
    stall = st; flush = fl; pcw = pw; tgt = tg;
  endtask

  task automatic do_reset(input int l);
    drive(0, 0, 1, 0);
    lat = l;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic apply(input vec_t v,
                       input string tag);
    drive(v.stall, v.flush, v.pcw, v.tgt);
    step();
    chk({tag, ".valid"}, 32'(ifid_valid),
        32'(v.e_valid));
    chk({tag, ".addr"}, addr, v.e_addr);
    chk({tag, ".req"}, 32'(req), 32'(v.e_req));
    if (v.e_valid) begin
      chk({tag, ".pc"}, ifid_pc, v.e_pc);
      chk({tag, ".instr"}, ifid_instr,
          mem_word(v.e_pc));
    end else begin
      chk({tag, ".nop"}, ifid_instr, NOP);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".rst_req"}, 32'(req), 0);
    chk({tag, ".rst_addr"}, addr, 0);
    chk({tag, ".rst_pc"}, ifid_pc, 0);
    chk({tag, ".rst_instr"}, ifid_instr, NOP);
    chk({tag, ".rst_valid"}, 32'(ifid_valid), 0);
  endtask

  initial begin
    drive(0, 0, 1, 0);
    t1[0] = mk(0, 0, 1, 0, 0, 0,  0, 1);
    t1[1] = mk(0, 0, 1, 0, 1, 0,  4, 1);
    t1[2] = mk(0, 0, 1, 0, 1, 4,  8, 1);
    t1[3] = mk(0, 0, 1, 0, 1, 8, 12, 1);
    t1[4] = mk(0, 0, 1, 0, 1, 12, 16, 1);

    t2[0] = mk(0, 0, 1, 0, 0, 0, 0, 1);
    t2[1] = mk(0, 0, 1, 0, 0, 0, 0, 1);
    t2[2] = mk(0, 0, 1, 0, 0, 0, 0, 1);
    t2[3] = mk(0, 0, 1, 0, 1, 0, 4, 1);
    t2[4] = mk(0, 0, 1, 0, 0, 0, 4, 1);
    t2[5] = mk(0, 0, 1, 0, 0, 0, 4, 1);
    t2[6] = mk(0, 0, 1, 0, 1, 4, 8, 1);

    // reset values
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("init");

    // zero-wait streaming
    do_reset(0);
    foreach (t1[i]) apply(t1[i], $sformatf("zw%0d", i));

    // latency 2
    do_reset(2);
    foreach (t2[i]) apply(t2[i], $sformatf("l2_%0d", i));

    // load-use stall into HOLD
    do_reset(0);
    step(); step(); step();
    chk("st.pre_pc", ifid_pc, 4);
    drive(1, 0, 0, 0);
    step();
    chk("st.hold_req", 32'(req), 0);
    chk("st.hold_pc", ifid_pc, 4);
    chk("st.hold_addr", addr, 8);
    drive(0, 0, 1, 0);
    step();
    chk("st.buf_pc", ifid_pc, 8);
    chk("st.buf_instr", ifid_instr, mem_word(8));
    chk("st.buf_valid", 32'(ifid_valid), 1);
    chk("st.next_addr", addr, 12);
    step();
    chk("st.after_pc", ifid_pc, 12);

    // flush during pending fetch, latency 3
    do_reset(3);
    step(); step();
    drive(0, 1, 1, 32'h0000_0103);
    step();
    chk("dr.bubble", 32'(ifid_valid), 0);
    drive(0, 0, 1, 0);
    step();
    chk("dr.req", 32'(req), 1);
    chk("dr.old_addr", addr, 0);
    step();
    chk("dr.redir_addr", addr, 32'h100);
    chk("dr.discard", 32'(ifid_valid), 0);
    step(); step(); step();
    chk("dr.lat_bubble", 32'(ifid_valid), 0);
    step();
    chk("dr.valid", 32'(ifid_valid), 1);
    chk("dr.pc", ifid_pc, 32'h100);
    chk("dr.instr", ifid_instr, mem_word(32'h100));

    // flush with stall is ignored
    do_reset(0);
    step(); step();
    drive(1, 1, 0, 32'h40);
    step();
    chk("fs.pc0", ifid_pc, 0);
    chk("fs.req0", 32'(req), 0);
    step();
    chk("fs.pc1", ifid_pc, 0);
    chk("fs.addr1", addr, 4);
    drive(0, 1, 1, 32'h40);
    step();
    chk("fs.bubble", 32'(ifid_valid), 0);
    chk("fs.addr2", addr, 32'h40);
    drive(0, 0, 1, 0);
    step();
    chk("fs.tgt_pc", ifid_pc, 32'h40);
    chk("fs.tgt_valid", 32'(ifid_valid), 1);

    // PC wrap
    do_reset(0);
    step();
    drive(0, 1, 1, 32'hFFFF_FFFC);
    step();
    chk("wr.addr_hi", addr, 32'hFFFF_FFFC);
    drive(0, 0, 1, 0);
    step();
    chk("wr.pc", ifid_pc, 32'hFFFF_FFFC);
    chk("wr.addr0", addr, 0);

    // async reset mid-DRAIN
    do_reset(0);
    step(); step();
    lat = 3;
    drive(0, 1, 1, 32'h80);
    step();
    drive(0, 0, 1, 0);
    step();
    chk("ar.drain_req", 32'(req), 1);
    chk("ar.drain_addr", addr, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("ar");
    lat = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ar.req", 32'(req), 1);
    chk("ar.addr", addr, 0);
    step();
    chk("ar.first_pc", ifid_pc, 0);
    chk("ar.first_valid", 32'(ifid_valid), 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
